tt_um_jimktrains_vslc_sequencer: RTL and testbench
==================================================

TT_UM_JIMKTRAINS_VSLC_SEQUENCER -- requirements
Module: tt_um_jimktrains_vslc_sequencer

Interface
REQ-001 Parameter PROG_DEPTH, default 16: number of program bytes stored.
REQ-002 Parameter PTR_W, default 4: width of program pointers, log2(PROG_DEPTH).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 ui_in  input  8  raw input pins, sampled once per scan.
REQ-006 run  input  1  high means program bytes are streamed continuously.
REQ-007 load_n  input  1  low selects program load mode.
REQ-008 sclk  input  1  asynchronous serial load clock.
REQ-009 sdata  input  1  serial load data, MSB first.
REQ-010 instr  output  8  current instruction byte to the executor.
REQ-011 instr_ready  output  1  byte strobe; the executor acts on its falling edge.
REQ-012 ui_in_scan  output  8  input image latched at scan start.
REQ-013 ui_in_prev  output  8  input image of the previous scan.
REQ-014 exec_rst_n  output  1  active-low reset to the executor.
REQ-015 scan_pulse  output  1  one-cycle pulse at the end of each scan.
REQ-016 overflow  output  1  sticky flag: more than PROG_DEPTH bytes were loaded.

Function
REQ-017 States: IDLE, LOAD, SCAN_START, SLOT_HI, SLOT_LO, SCAN_END.
REQ-018 IDLE: load_n low -> LOAD; else run high and prog_len != 0 -> SCAN_START; else stay.
REQ-019 LOAD: sclk and sdata each pass a 2-FF synchronizer; each synchronized sclk rise shifts sdata into an 8-bit shift register, MSB first.
REQ-020 LOAD: the 8th shifted bit writes the assembled byte to mem[wr_ptr] and increments wr_ptr.
REQ-021 LOAD: a write attempted with wr_ptr at PROG_DEPTH SHALL be dropped and set overflow.
REQ-022 LOAD: while in LOAD, exec_rst_n=0 and instr_ready=0.
REQ-023 On load_n rising: prog_len<=wr_ptr, partial bits are discarded, wr_ptr and bit count clear, next state is IDLE.
REQ-024 SCAN_START (1 cycle): ui_in_prev<=ui_in_scan, ui_in_scan<=ui_in, rd_ptr<=0, then SLOT_HI.
REQ-025 SLOT_HI (1 cycle): instr<=mem[rd_ptr] on entry, instr_ready=1, then SLOT_LO.
REQ-026 SLOT_LO (1 cycle): instr_ready=0 with instr unchanged; rd_ptr+1==prog_len -> SCAN_END, else rd_ptr++ and SLOT_HI.
REQ-027 instr SHALL change only on entry to SLOT_HI, so it is stable at both executor negedges of the slot.
REQ-028 SCAN_END (1 cycle): scan_pulse=1; then SCAN_START if run high and load_n high, else IDLE.
REQ-029 Throughput: each byte takes exactly 2 cycles, so a scan takes 2*prog_len+2 cycles.
REQ-030 load_n low in any run state SHALL abort at the next edge: go to LOAD with instr_ready=0 and no scan_pulse.
REQ-031 run falling mid-scan SHALL finish the current scan and then enter IDLE.
REQ-032 prog_len==0 SHALL never leave IDLE except to enter LOAD.
REQ-033 Outside LOAD, exec_rst_n follows rst_n.

Reset
REQ-034 While rst_n is low at a clock edge: state=IDLE; instr, instr_ready, ui_in_scan, ui_in_prev, scan_pulse, overflow, prog_len, wr_ptr, rd_ptr and the shift register all clear; exec_rst_n=0.
REQ-035 Program memory contents are not reset; prog_len=0 makes them unreachable.

Structure
REQ-036 The state encoding, PROG_DEPTH and the slot length constant SHALL be in shared package tt_um_jimktrains_vslc_pkg.
REQ-037 One sub-module, tt_um_jimktrains_vslc_serial_loader, SHALL hold the synchronizers, shift register and byte-valid strobe.

Verification
REQ-038 Load bytes 0x01,0x50 and release load_n -> prog_len=2; with run=1, instr shows 0x01 then 0x50, instr_ready toggles 1,0,1,0, and scan_pulse recurs every 6 cycles.
REQ-039 ui_in=0x0F at the first scan, then 0xF0 -> at the second scan ui_in_scan=0xF0 and ui_in_prev=0x0F.
REQ-040 Load 17 bytes -> overflow=1, prog_len=16, and byte 17 is never emitted.
REQ-041 Pull load_n low during SLOT_HI -> next cycle instr_ready=0 and exec_rst_n=0, with no scan_pulse.
REQ-042 Drop run during byte 1 of 3 -> bytes 2 and 3 are emitted, scan_pulse fires once, then state is IDLE.
REQ-043 Assert rst_n low mid-scan -> on the next edge all outputs are 0 and prog_len=0; with run=1 after reset, no strobes occur.

Source files
------------

// File: rtl/tt_um_jimktrains_vslc_pkg.sv
// Shared definitions for the VSLC program sequencer: sequencer states, default
// program depth/pointer width and the per-byte slot length.
package tt_um_jimktrains_vslc_pkg;

  localparam int PROG_DEPTH  = 16;
  localparam int PTR_W       = 4;
  localparam int SLOT_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LOAD       = 3'd1,
    SCAN_START = 3'd2,
    SLOT_HI    = 3'd3,
    SLOT_LO    = 3'd4,
    SCAN_END   = 3'd5
  } state_t;

endpackage

// File: rtl/tt_um_jimktrains_vslc_if.sv
// Sequencer-to-executor bus: instruction stream, input images, executor reset
// and the end-of-scan pulse.
interface tt_um_jimktrains_vslc_if;

  logic [7:0] instr;
  logic       instr_ready;
  logic [7:0] ui_in_scan;
  logic [7:0] ui_in_prev;
  logic       exec_rst_n;
  logic       scan_pulse;

  modport master (
    output instr,
    output instr_ready,
    output ui_in_scan,
    output ui_in_prev,
    output exec_rst_n,
    output scan_pulse
  );

  modport slave (
    input instr,
    input instr_ready,
    input ui_in_scan,
    input ui_in_prev,
    input exec_rst_n,
    input scan_pulse
  );

endinterface

// File: rtl/tt_um_jimktrains_vslc_serial_loader.sv
// Serial program loader: synchronizes the external sclk/sdata pair, shifts bits
// MSB first and strobes byte_valid for one cycle when a full byte is assembled.
module tt_um_jimktrains_vslc_serial_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       sclk,
  input  logic       sdata,
  output logic [7:0] byte_data,
  output logic       byte_valid
);

  logic [1:0] sclk_sync;
  logic [1:0] sdata_sync;
  logic       sclk_prev;
  logic [7:0] shift_reg;
  logic [2:0] bit_cnt;
  logic       sclk_rise;

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[0], sclk};
      sdata_sync <= {sdata_sync[0], sdata};
      sclk_prev  <= sclk_sync[1];
      byte_valid <= 1'b0;
      // Leaving load mode throws away any partially shifted byte.
      if (!enable) begin
        shift_reg <= '0;
        bit_cnt   <= '0;
      end else if (sclk_rise) begin
        shift_reg <= {shift_reg[6:0], sdata_sync[1]};
        bit_cnt   <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_data  <= {shift_reg[6:0], sdata_sync[1]};
          byte_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tt_um_jimktrains_vslc_sequencer.sv
// VSLC program sequencer: loads a byte program serially, then streams it to the
// executor once per scan, two cycles per byte, latching the input image per scan.
//
// state      | meaning
// IDLE       | waiting for load_n low or run with a non-empty program
// LOAD       | executor held in reset, serial bytes written to memory
// SCAN_START | latch input image, rewind read pointer
// SLOT_HI    | instr valid, instr_ready high
// SLOT_LO    | instr held, instr_ready low, advance or finish
// SCAN_END   | one-cycle scan_pulse, restart or return to IDLE
module tt_um_jimktrains_vslc_sequencer #(
  parameter int PROG_DEPTH = tt_um_jimktrains_vslc_pkg::PROG_DEPTH,
  parameter int PTR_W      = tt_um_jimktrains_vslc_pkg::PTR_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ui_in,
  input  logic       run,
  input  logic       load_n,
  input  logic       sclk,
  input  logic       sdata,
  output logic       overflow,
  tt_um_jimktrains_vslc_if.master bus
);

  import tt_um_jimktrains_vslc_pkg::*;

  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(PROG_DEPTH);

  state_t           state;
  state_t           next_state;
  logic [7:0]       mem [PROG_DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   prog_len;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [7:0]       load_byte;
  logic             load_valid;
  logic             in_load;
  logic             mem_full;
  logic             last_slot;

  assign in_load   = (state == LOAD);
  assign mem_full  = (wr_ptr == DEPTH_CNT);
  assign last_slot = (({1'b0, rd_ptr} + (PTR_W + 1)'(1)) == prog_len);

  tt_um_jimktrains_vslc_serial_loader u_loader (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (in_load),
    .sclk       (sclk),
    .sdata      (sdata),
    .byte_data  (load_byte),
    .byte_valid (load_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!load_n)                    next_state = LOAD;
        else if (run && prog_len != '0) next_state = SCAN_START;
      end
      LOAD: begin
        if (load_n) next_state = IDLE;
      end
      SCAN_START: next_state = load_n ? SLOT_HI : LOAD;
      SLOT_HI:    next_state = load_n ? SLOT_LO : LOAD;
      SLOT_LO: begin
        if (!load_n)        next_state = LOAD;
        else if (last_slot) next_state = SCAN_END;
        else                next_state = SLOT_HI;
      end
      SCAN_END: begin
        if (!load_n)  next_state = LOAD;
        else if (run) next_state = SCAN_START;
        else          next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.instr_ready = (state == SLOT_HI);
    bus.scan_pulse  = (state == SCAN_END);
    bus.exec_rst_n  = rst_n && (state != LOAD);
  end

  always_comb begin
    rd_next = rd_ptr;
    if (state == SCAN_START)
      rd_next = '0;
    else if (state == SLOT_LO && next_state == SLOT_HI)
      rd_next = rd_ptr + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.instr      <= '0;
      bus.ui_in_scan <= '0;
      bus.ui_in_prev <= '0;
      overflow       <= 1'b0;
      prog_len       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
    end else begin
      rd_ptr <= rd_next;
      // instr only moves on entry to SLOT_HI so it is stable across the slot.
      if (next_state == SLOT_HI)
        bus.instr <= mem[rd_next];
      if (state == SCAN_START) begin
        bus.ui_in_prev <= bus.ui_in_scan;
        bus.ui_in_scan <= ui_in;
      end
      if (in_load) begin
        if (load_n) begin
          prog_len <= wr_ptr;
          wr_ptr   <= '0;
        end else if (load_valid) begin
          if (mem_full) overflow <= 1'b1;
          else          wr_ptr   <= wr_ptr + (PTR_W + 1)'(1);
        end
      end
    end
  end

  // Program memory is deliberately not reset; prog_len gates all reads.
  always_ff @(posedge clk) begin
    if (in_load && !load_n && load_valid && !mem_full)
      mem[wr_ptr[PTR_W-1:0]] <= load_byte;
  end

endmodule

// File: tb/tb_tt_um_jimktrains_vslc_sequencer.sv
// Self-checking bench: random programs and input images compared against an
// expected byte stream, scan period and input-image history.
module tb_tt_um_jimktrains_vslc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic       run = 1'b0;
  logic       load_n = 1'b1;
  logic       sclk = 1'b0;
  logic       sdata = 1'b0;
  logic       overflow;

  tt_um_jimktrains_vslc_if bus();

  tt_um_jimktrains_vslc_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ui_in    (ui_in),
    .run      (run),
    .load_n   (load_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .overflow (overflow),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] prog[$];
  logic [7:0] ui_force[$];
  logic [7:0] last_scan;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] next_ui();
    if (ui_force.size() > 0) return ui_force.pop_front();
    return 8'($urandom);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sdata = b[i];
      cyc(3);
      sclk = 1'b1;
      cyc(4);
      sclk = 1'b0;
      cyc(3);
    end
  endtask

  // Model: the stored program is the first 16 bytes shifted in.
  task automatic load_prog(input logic [7:0] bytes[$]);
    run    = 1'b0;
    load_n = 1'b0;
    cyc(2);
    chk("load_exec_rst", 32'(bus.exec_rst_n), 0);
    chk("load_strobe", 32'(bus.instr_ready), 0);
    foreach (bytes[i]) send_byte(bytes[i]);
    cyc(6);
    load_n = 1'b1;
    cyc(2);
    prog = {};
    foreach (bytes[i]) if (i < 16) prog.push_back(bytes[i]);
  endtask

  task automatic quiet(input int n, input string tag);
    int s;
    s = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus.instr_ready || bus.scan_pulse) s++;
    end
    chk(tag, s, 0);
  endtask

  task automatic wait_strobe();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (bus.instr_ready) ok = 1'b1;
    end
    chk("strobe_seen", 32'(ok), 1);
  endtask

  task automatic run_scans(input int n);
    int idx, scans, last_pulse, len, budget;
    logic [7:0] cur_ui;
    len = prog.size();
    idx = 0;
    scans = 0;
    last_pulse = -1;
    budget = 4 * (2 * len + 2) * n + 20;
    cur_ui = next_ui();
    ui_in = cur_ui;
    run = 1'b1;
    for (int c = 0; c < budget && scans < n; c++) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        if (idx < len) chk("instr", 32'(bus.instr), 32'(prog[idx]));
        else           chk("extra_strobe", idx, len);
        idx++;
      end else if (idx > 0 && idx <= len) begin
        chk("instr_hold", 32'(bus.instr), 32'(prog[idx-1]));
      end
      if (bus.scan_pulse) begin
        chk("bytes_in_scan", idx, len);
        chk("ui_in_scan", 32'(bus.ui_in_scan), 32'(cur_ui));
        chk("ui_in_prev", 32'(bus.ui_in_prev), 32'(last_scan));
        if (last_pulse >= 0) chk("scan_period", c - last_pulse, 2 * len + 2);
        last_pulse = c;
        last_scan = cur_ui;
        scans++;
        idx = 0;
        if (scans == n) run = 1'b0;
        else begin
          cur_ui = next_ui();
          ui_in = cur_ui;
        end
      end
    end
    run = 1'b0;
    chk("scans_done", scans, n);
    quiet(12, "idle_after_scans");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bytes[$];
    int s, p;

    last_scan = 8'h00;
    rst_n = 1'b0;
    cyc(3);
    chk("rst_instr", 32'(bus.instr), 0);
    chk("rst_instr_ready", 32'(bus.instr_ready), 0);
    chk("rst_scan_pulse", 32'(bus.scan_pulse), 0);
    chk("rst_exec_rst", 32'(bus.exec_rst_n), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_ui_scan", 32'(bus.ui_in_scan), 0);
    chk("rst_ui_prev", 32'(bus.ui_in_prev), 0);
    rst_n = 1'b1;
    cyc(1);
    chk("exec_rst_release", 32'(bus.exec_rst_n), 1);
    run = 1'b1;
    quiet(20, "empty_prog_idle");
    run = 1'b0;

    bytes = '{8'h01, 8'h50};
    load_prog(bytes);
    chk("no_overflow", 32'(overflow), 0);
    ui_force = '{8'h0F, 8'hF0};
    run_scans(3);

    for (int t = 0; t < 4; t++) begin
      bytes = {};
      for (int k = 0, n = $urandom_range(1, 16); k < n; k++) bytes.push_back(8'($urandom));
      load_prog(bytes);
      chk("no_overflow", 32'(overflow), 0);
      run_scans($urandom_range(2, 3));
    end

    // run dropped during the first byte of three: scan still completes once
    bytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
    load_prog(bytes);
    ui_in = 8'($urandom);
    run = 1'b1;
    wait_strobe();
    chk("drop_first", 32'(bus.instr), 32'(bytes[0]));
    run = 1'b0;
    s = 0;
    p = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.instr_ready) begin
        if (s < 2) chk("drop_instr", 32'(bus.instr), 32'(bytes[s+1]));
        s++;
      end
      if (bus.scan_pulse) begin
        chk("drop_ui_scan", 32'(bus.ui_in_scan), 32'(ui_in));
        p++;
      end
    end
    chk("drop_strobes", s, 2);
    chk("drop_pulses", p, 1);
    last_scan = ui_in;
    quiet(10, "drop_idle");

    // abort a running scan with load_n; an empty load leaves prog_len at zero
    bytes = '{8'($urandom), 8'($urandom), 8'($urandom)};
    load_prog(bytes);
    run = 1'b1;
    wait_strobe();
    load_n = 1'b0;
    cyc(1);
    chk("abort_strobe", 32'(bus.instr_ready), 0);
    chk("abort_exec_rst", 32'(bus.exec_rst_n), 0);
    chk("abort_pulse", 32'(bus.scan_pulse), 0);
    quiet(8, "abort_quiet");
    load_n = 1'b1;
    cyc(2);
    quiet(20, "abort_len0_idle");
    run = 1'b0;

    // 17 bytes: only 16 stored, overflow sticks
    bytes = {};
    for (int k = 0; k < 17; k++) bytes.push_back(8'($urandom));
    load_prog(bytes);
    chk("overflow_set", 32'(overflow), 1);
    run_scans(2);
    chk("overflow_sticky", 32'(overflow), 1);

    // synchronous reset in the middle of a scan
    ui_in = 8'($urandom);
    run = 1'b1;
    wait_strobe();
    rst_n = 1'b0;
    cyc(1);
    chk("mrst_instr", 32'(bus.instr), 0);
    chk("mrst_instr_ready", 32'(bus.instr_ready), 0);
    chk("mrst_scan_pulse", 32'(bus.scan_pulse), 0);
    chk("mrst_exec_rst", 32'(bus.exec_rst_n), 0);
    chk("mrst_overflow", 32'(overflow), 0);
    chk("mrst_ui_scan", 32'(bus.ui_in_scan), 0);
    chk("mrst_ui_prev", 32'(bus.ui_in_prev), 0);
    rst_n = 1'b1;
    last_scan = 8'h00;
    quiet(20, "post_reset_idle");
    run = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
